// File: rtl/enemy_control.sv
// enemy_control: per-frame sequencer that erases the old enemy sprites, loads new
// coordinates, redraws them, then signals completion; pause freezes an active pass.
module enemy_control #(
  parameter int NUM_ENEMY     = 10,
  parameter int PIX_PER_ENEMY = 25,
  parameter int CW            = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_tick,
  input  logic pause,
  output logic load_coord,
  output logic enable,
  output logic op,
  output logic plot,
  output logic busy,
  output logic done,
  output logic overrun
);
  localparam int P = NUM_ENEMY * PIX_PER_ENEMY;
  localparam logic [CW-1:0] LAST = CW'(P - 1);
  typedef enum logic [2:0] {IDLE, ERASE, LOAD, DRAW, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic first_q, first_d;
  // enable is the registered "unpaused pass cycle" flag, so it also gates the counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:        state_d = frame_tick ? (first_q ? LOAD : ERASE) : IDLE;
      ERASE, DRAW: if (enable) begin
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q != LAST) ? state_q : (state_q == ERASE) ? LOAD : DONE;
      end
      LOAD:        state_d = DRAW;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    first_d = first_q && (state_d != LOAD);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      load_coord <= 1'b0;
      enable     <= 1'b0;
      op         <= 1'b0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      load_coord <= state_d == LOAD;
      enable     <= (state_d == ERASE || state_d == DRAW) && !pause;
      plot       <= (state_d == ERASE || state_d == DRAW) && !pause;
      op         <= state_d == DRAW;
      busy       <= state_d != IDLE;
      done       <= state_d == DONE;
      overrun    <= frame_tick && busy;
    end
  end
endmodule

// File: tb/tb_enemy_control.sv
// tb_enemy_control: random and directed frames checked against a pass-stream model.
module tb_enemy_control;
  localparam int P = 250;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_tick = 1'b0;
  logic pause = 1'b0;
  logic tick3 = 1'b0;
  logic load_coord, enable, op, plot, busy, done, overrun;
  logic load3, enable3, op3, plot3, busy3, done3, overrun3;
  int checks = 0;
  int failures = 0;
  int m_s, m_len;
  bit m_act, m_first, m_pq, m_ov;
  wire [6:0] vec = {load_coord, enable, op, plot, busy, done, overrun};

  always #5 clk = ~clk;

  enemy_control dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .pause(pause),
    .load_coord(load_coord), .enable(enable), .op(op), .plot(plot),
    .busy(busy), .done(done), .overrun(overrun)
  );

  enemy_control #(.NUM_ENEMY(3), .PIX_PER_ENEMY(25), .CW(7)) dut3 (
    .clk(clk), .reset_n(reset_n), .frame_tick(tick3), .pause(1'b0),
    .load_coord(load3), .enable(enable3), .op(op3), .plot(plot3),
    .busy(busy3), .done(done3), .overrun(overrun3)
  );

  // A frame is a stream of items: [P erase] (normal frames only), load, [P draw], done
  function automatic int kind(int s, int len);
    int off = (len == 2 * P + 2) ? P : 0;
    return s < off ? 0 : s == off ? 1 : s <= off + P ? 2 : 3;
  endfunction

  function automatic logic [6:0] exp_out();
    int k = m_act ? kind(m_s, m_len) : -1;
    logic en = (k == 0 || k == 2) && !m_pq;
    return {k == 1, en, k == 2, en, m_act, k == 3, m_ov};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 0; m_first <= 1; m_pq <= 0; m_ov <= 0; m_s <= 0; m_len <= 0;
    end else begin
      m_ov <= frame_tick && m_act;
      m_pq <= pause;
      if (!m_act) begin
        if (frame_tick) begin
          m_act <= 1; m_s <= 0; m_first <= 0;
          m_len <= m_first ? P + 2 : 2 * P + 2;
        end
      end else begin
        case (kind(m_s, m_len))
          0, 2:    if (!m_pq) m_s <= m_s + 1;
          1:       m_s <= m_s + 1;
          default: m_act <= 0;
        endcase
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit t, input bit p);
    frame_tick = t;
    pause = p;
    @(negedge clk);
    check("outs", int'(vec), int'(exp_out()));
  endtask

  task automatic frame(input int pa, input int pl, input int ta, output int lat, output int ens);
    cyc(1, 0);
    lat = 1;
    ens = 0;
    while (!done && lat < 3000) begin
      ens += int'(enable);
      cyc(lat == ta, lat >= pa && lat < pa + pl);
      lat++;
    end
    cyc(0, 0);
  endtask

  task automatic frame3(output int lat, output int ens);
    tick3 = 1;
    cyc(0, 0);
    tick3 = 0;
    lat = 1;
    ens = 0;
    while (!done3 && lat < 1000) begin
      ens += int'(enable3);
      cyc(0, 0);
      lat++;
    end
    cyc(0, 0);
  endtask

  initial begin
    int lat, ens;
    repeat (3) cyc(0, 0);
    check("reset_outs", int'(vec), 0);
    reset_n = 1;
    cyc(0, 0);
    frame(-1, 0, -1, lat, ens);
    check("first_latency", lat, P + 2);
    check("first_enables", ens, P);
    frame(-1, 0, -1, lat, ens);
    check("normal_latency", lat, 2 * P + 2);
    check("normal_enables", ens, 2 * P);
    frame(100, 10, -1, lat, ens);
    check("pause_latency", lat, 2 * P + 12);
    check("pause_enables", ens, 2 * P);
    frame(-1, 0, 300, lat, ens);
    check("overrun_latency", lat, 2 * P + 2);
    repeat (5) cyc(0, 0);
    check("no_extra_pass", int'(busy), 0);
    cyc(1, 0);
    repeat (P + 38) cyc(0, 0);
    check("mid_draw_op", int'(op), 1);
    #2 reset_n = 0;
    #1 check("async_reset", int'(vec), 0);
    cyc(0, 0);
    reset_n = 1;
    cyc(0, 0);
    frame(-1, 0, -1, lat, ens);
    check("post_reset_latency", lat, P + 2);
    frame3(lat, ens);
    check("p75_first", lat, 77);
    frame3(lat, ens);
    check("p75_normal", lat, 152);
    check("p75_enables", ens, 150);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(1999) == 0) begin
        reset_n = 0;
        cyc(0, 0);
        reset_n = 1;
      end
      cyc($urandom_range(149) == 0, $urandom_range(7) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/enemy_control.md
ENEMY_CONTROL -- requirements
Module: enemy_control

Interface
REQ-001 Parameter NUM_ENEMY, default 10, number of enemy sprites per pass.
REQ-002 Parameter PIX_PER_ENEMY, default 25, pixels per sprite (5x5).
REQ-003 Parameter CW, default 8, pixel-counter width; SHALL satisfy 2^CW >= NUM_ENEMY*PIX_PER_ENEMY.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 frame_tick  input  1  one-cycle pulse requesting a screen update.
REQ-007 pause  input  1  level; freezes an active pass.
REQ-008 load_coord  output  1  one-cycle strobe; datapath captures new enemy coordinates.
REQ-009 enable  output  1  advances datapath select/pixel counters.
REQ-010 op  output  1  0 = erase (black), 1 = draw (sprite colours).
REQ-011 plot  output  1  VGA write enable.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at update completion.
REQ-014 overrun  output  1  one-cycle pulse when a frame_tick is dropped.

Function
REQ-015 FSM states SHALL be IDLE, ERASE, LOAD, DRAW and DONE; encoding is free.
REQ-016 Pass length SHALL be P = NUM_ENEMY*PIX_PER_ENEMY cycles (250 at defaults); the CW-bit pixel counter runs 0..P-1.
REQ-017 IDLE with frame_tick=1 SHALL go to ERASE, or to LOAD if first_frame=1; first_frame is set by reset and cleared on entry to LOAD.
REQ-018 ERASE: op=0; enable=plot=1 on each unpaused cycle; counter increments per unpaused cycle; when the counter is P-1 on an unpaused cycle, go to LOAD with the counter cleared to 0.
REQ-019 LOAD SHALL last exactly one cycle with load_coord=1 and enable=plot=0, then go to DRAW.
REQ-020 DRAW: op=1 and is otherwise identical to ERASE; when the counter is P-1 on an unpaused cycle, go to DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-022 In ERASE and DRAW, pause=1 SHALL hold the state and counter and force enable=plot=0; op holds its value.
REQ-023 pause SHALL have no effect in IDLE, LOAD or DONE.
REQ-024 A frame_tick while busy=1 SHALL be dropped, pulse overrun in the following cycle, and leave the state and counter unchanged.
REQ-025 All outputs SHALL be registered or decoded from state only; no input-to-output combinational paths.
REQ-026 Latency SHALL be 2P+2 cycles from the frame_tick edge to the done pulse for a normal frame, and P+2 cycles for the first frame, when unpaused.
REQ-027 Each unpaused ERASE or DRAW pass SHALL assert enable for exactly P cycles so that the datapath select counter returns to sprite 0.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, counter=0 and first_frame=1, and force load_coord, enable, op, plot, busy, done and overrun to 0.
REQ-029 Reset asserted mid-pass SHALL abort the pass with no done pulse; the next frame_tick after release is treated as a first frame.

Verification
REQ-030 Reset release, then a frame_tick -> LOAD for 1 cycle, 250 cycles of DRAW with plot=1 and op=1, then done at cycle 252; no ERASE cycles.
REQ-031 Second frame_tick -> 250 cycles with op=0 and plot=1, load_coord at cycle 251, 250 cycles with op=1, done at cycle 502.
REQ-032 pause held 10 cycles at ERASE count 100 -> enable=plot=0 for those cycles, count stays 100, done at cycle 512.
REQ-033 frame_tick during DRAW -> overrun pulses once, done timing is unchanged, and no extra pass occurs.
REQ-034 reset_n low at DRAW count 37 -> all outputs 0 asynchronously; the next tick yields done after 252 cycles.
REQ-035 NUM_ENEMY=3, PIX_PER_ENEMY=25 -> P=75 and a normal frame completes in 152 cycles.
